// File: rtl/reorder_buffer_if.sv
// Issue, broadcast, query and retire signals between the decoder/execution
// side (master) and the reorder buffer (slave).
interface reorder_buffer_if #(parameter int W = 4);
  logic         issue_valid;
  logic [1:0]   issue_type;
  logic [4:0]   issue_rd;
  logic         issue_pred_taken;
  logic [31:0]  issue_alt_pc;
  logic [W-1:0] issue_rob_id;
  logic         rob_full;

  logic         rs_ready;
  logic [W-1:0] rs_rob_id;
  logic [31:0]  rs_value;
  logic         lsb_ready;
  logic [W-1:0] lsb_rob_id;
  logic [31:0]  lsb_value;

  logic [W-1:0] query1_id;
  logic [W-1:0] query2_id;
  logic         query1_ready;
  logic         query2_ready;
  logic [31:0]  query1_value;
  logic [31:0]  query2_value;

  logic         commit_reg_valid;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_value;
  logic [W-1:0] commit_rob_id;
  logic         commit_store_valid;
  logic         rob_clear;
  logic [31:0]  clear_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    output query1_id, query2_id,
    input  issue_rob_id, rob_full, query1_ready, query2_ready, query1_value, query2_value,
    input  commit_reg_valid, commit_rd, commit_value, commit_rob_id, commit_store_valid,
    input  rob_clear, clear_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    input  query1_id, query2_id,
    output issue_rob_id, rob_full, query1_ready, query2_ready, query1_value, query2_value,
    output commit_reg_valid, commit_rd, commit_value, commit_rob_id, commit_store_valid,
    output rob_clear, clear_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire of results collected from the ALU
// and LSB broadcast buses, with a flush on branch misprediction.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  reorder_buffer_if.slave   bus
);
  localparam int W     = ROB_SIZE_WIDTH;
  localparam int DEPTH = 1 << W;
  localparam int CW    = W + 1;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_JUMP   = 2'd3;

  logic [W-1:0]     head;
  logic [W-1:0]     tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] busy;

  logic [DEPTH-1:0] e_ready;
  logic [1:0]       e_type  [DEPTH];
  logic [4:0]       e_rd    [DEPTH];
  logic [31:0]      e_value [DEPTH];
  logic             e_pred  [DEPTH];
  logic [31:0]      e_alt   [DEPTH];

  logic issue_ok;
  logic wb_rs;
  logic wb_lsb;
  logic do_commit;
  logic do_flush;

  assign bus.rob_full     = (count == CW'(DEPTH));
  assign bus.issue_rob_id = tail;

  // Anything arriving while a flush is being signalled belongs to the wrong path.
  assign issue_ok  = bus.issue_valid && !bus.rob_full && !bus.rob_clear;
  assign wb_rs     = bus.rs_ready  && busy[bus.rs_rob_id]  && !bus.rob_clear;
  assign wb_lsb    = bus.lsb_ready && busy[bus.lsb_rob_id] && !bus.rob_clear;
  assign do_commit = busy[head] && e_ready[head];
  assign do_flush  = do_commit && (e_type[head] == T_BRANCH) &&
                     (e_value[head][0] != e_pred[head]);

  always_comb begin
    bus.query1_ready = 1'b0;
    bus.query1_value = '0;
    if (busy[bus.query1_id] && e_ready[bus.query1_id]) begin
      bus.query1_ready = 1'b1;
      bus.query1_value = e_value[bus.query1_id];
    end else if (bus.rs_ready && bus.rs_rob_id == bus.query1_id) begin
      bus.query1_ready = 1'b1;
      bus.query1_value = bus.rs_value;
    end else if (bus.lsb_ready && bus.lsb_rob_id == bus.query1_id) begin
      bus.query1_ready = 1'b1;
      bus.query1_value = bus.lsb_value;
    end
  end

  always_comb begin
    bus.query2_ready = 1'b0;
    bus.query2_value = '0;
    if (busy[bus.query2_id] && e_ready[bus.query2_id]) begin
      bus.query2_ready = 1'b1;
      bus.query2_value = e_value[bus.query2_id];
    end else if (bus.rs_ready && bus.rs_rob_id == bus.query2_id) begin
      bus.query2_ready = 1'b1;
      bus.query2_value = bus.rs_value;
    end else if (bus.lsb_ready && bus.lsb_rob_id == bus.query2_id) begin
      bus.query2_ready = 1'b1;
      bus.query2_value = bus.lsb_value;
    end
  end

  // Payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_ok) begin
        e_ready[tail] <= 1'b0;
        e_type[tail]  <= bus.issue_type;
        e_rd[tail]    <= bus.issue_rd;
        e_pred[tail]  <= bus.issue_pred_taken;
        e_alt[tail]   <= bus.issue_alt_pc;
      end
      if (wb_rs) begin
        e_ready[bus.rs_rob_id] <= 1'b1;
        e_value[bus.rs_rob_id] <= bus.rs_value;
      end
      if (wb_lsb) begin
        e_ready[bus.lsb_rob_id] <= 1'b1;
        e_value[bus.lsb_rob_id] <= bus.lsb_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                   <= '0;
      tail                   <= '0;
      count                  <= '0;
      busy                   <= '0;
      bus.commit_reg_valid   <= 1'b0;
      bus.commit_store_valid <= 1'b0;
      bus.commit_rd          <= '0;
      bus.commit_value       <= '0;
      bus.commit_rob_id      <= '0;
      bus.rob_clear          <= 1'b0;
      bus.clear_pc           <= '0;
    end else if (rdy) begin
      bus.commit_reg_valid   <= 1'b0;
      bus.commit_store_valid <= 1'b0;
      bus.rob_clear          <= 1'b0;
      if (do_flush) begin
        busy          <= '0;
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        bus.rob_clear <= 1'b1;
        bus.clear_pc  <= e_alt[head];
      end else begin
        if (issue_ok) begin
          busy[tail] <= 1'b1;
          tail       <= tail + W'(1);
        end
        if (do_commit) begin
          busy[head]        <= 1'b0;
          head              <= head + W'(1);
          bus.commit_rd     <= e_rd[head];
          bus.commit_value  <= e_value[head];
          bus.commit_rob_id <= head;
          case (e_type[head])
            T_REG, T_JUMP: bus.commit_reg_valid   <= 1'b1;
            T_STORE:       bus.commit_store_valid <= 1'b1;
            default:       ;
          endcase
        end
        count <= count + CW'(issue_ok) - CW'(do_commit);
      end
    end
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that sits directly downstream of the reservation station and load/store buffer. It allocates one entry per issued instruction and collects results from the ALU (RS) and LSB broadcast buses. It retires at most one entry per cycle, in program order, to the register file or the LSB. A branch whose resolved direction differs from its prediction raises `rob_clear` to flush the machine.

## Interface
- `ROB_SIZE_WIDTH`, default 4, index width; depth = 2^ROB_SIZE_WIDTH (16)
- `clk` in 1: the single clock
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: when low, all state and outputs hold
- `issue_valid` in 1: Decoder issues one instruction this cycle
- `issue_type` in 2: 0 = reg write, 1 = store, 2 = branch (writes no reg), 3 = jump (writes rd, never mispredicts)
- `issue_rd` in 5: destination register
- `issue_pred_taken` in 1: predicted direction (branch only)
- `issue_alt_pc` in 32: redirect PC used on misprediction
- `issue_rob_id` out W: tail index; the id assigned if issued this cycle
- `rob_full` out 1: no free entry; issue ignored while high
- `rs_ready`, `rs_rob_id`, `rs_value` in 1/W/32: ALU broadcast; for branches `rs_value[0]` = actual taken
- `lsb_ready`, `lsb_rob_id`, `lsb_value` in 1/W/32: LSB broadcast (load data, or store address/data ready)
- `query1_id`, `query2_id` in W: Decoder operand lookup
- `query1_ready`, `query2_ready` out 1 and `query1_value`, `query2_value` out 32: combinational lookup results
- `commit_reg_valid` out 1, `commit_rd` out 5, `commit_value` out 32, `commit_rob_id` out W: register retire pulse
- `commit_store_valid` out 1: store retire pulse; id on `commit_rob_id`
- `rob_clear` out 1: flush pulse
- `clear_pc` out 32: fetch redirect target, valid while `rob_clear` is high

## Operation
- State: `head`, `tail` (W bits, wrap modulo 2^W), `count` (W+1 bits). Per entry: `busy`, `ready`, `type`, `rd`, `value`, `pred_taken`, `alt_pc`.
- `rob_full` = (`count` == 2^W). `issue_rob_id` = `tail`.
- **Issue:** if `issue_valid` && !`rob_full` && !`rob_clear`, the entry at `tail` gets `busy`=1 and `ready`=0, fields are captured, and `tail`++.
- **Writeback:** for each of the RS and LSB buses, if ready and the addressed entry is busy, set `ready`=1 and `value`=bus value. The two buses never target the same id in one cycle.
- **Query:**
  - ready=1 if entry busy && ready, or the id matches an RS/LSB broadcast this cycle (bypass, with the bus value).
  - Otherwise ready=0 and value=0.
- **Commit:** when `head` entry is busy && ready, retire it, clear `busy`, and `head`++.
  - Type 0/3: `commit_reg_valid`=1 with rd/value/id.
  - Type 1: `commit_store_valid`=1.
  - Type 2, `value[0]` == `pred_taken`: no output pulse.
  - Type 2, `value[0]` != `pred_taken`: `rob_clear`=1, `clear_pc`=`alt_pc`. All `busy` cleared; `head`=`tail`=`count`=0.
- `count` += issue − commit. Simultaneous issue and commit leaves it unchanged, including when full: a full ROB that commits still rejects that cycle's issue, because `rob_full` is evaluated on current state.
- While `rob_clear` is high, issue and writeback inputs are ignored.

## Timing
- All outputs except the query and `issue_rob_id`/`rob_full` paths are registered. Their reset values are 0: `rob_full`, `rob_clear`, `clear_pc`, every commit signal, and `issue_rob_id`. Reset also sets `head`=`tail`=`count`=0 and all `busy`=0.
- Commit pulses last exactly 1 cycle.
- Issue at edge N. The earliest writeback is at edge N+1, and the earliest commit pulse is visible after edge N+2.
- Mispredict: `rob_clear` is high for the cycle after the committing edge. The first accepted issue is at the edge after `rob_clear` falls.
- Reset mid-operation overrides commit, clear and issue at that edge.
- `rdy` low freezes pulses at their current values: no new commit, issue or writeback.
- Throughput: 1 issue and 1 commit per cycle sustained.

## Test plan
- Reset, then 16 issues of type 0 with no writeback: ids 0..15 are assigned, and `rob_full`=1 after the 16th. A 17th `issue_valid` is ignored (`tail` stays 0).
- Issue ids 0,1,2. RS writes id 2 (value 0x33), then id 0 (0x11), then id 1 (0x22): commits occur in order 0,1,2 with values 0x11, 0x22, 0x33, and none before id 0 is ready.
- Branch at id 0 predicted taken, with id 1 also issued. RS sends id 0 with `rs_value`=0: a 1-cycle `rob_clear` with `clear_pc` = `alt_pc` (e.g. 0x104). Afterwards `count`=0, the next issue gets id 0, and id 1 never commits.
- Same branch with `rs_value`=1: no `rob_clear`, no commit pulse, `head` advances.
- Query bypass: `query1_id`=3 while RS broadcasts id 3 with 0xABCD: `query1_ready`=1 and `query1_value`=0xABCD in the same cycle.
- Wrap-around: with the ROB full and `head` committing, the same cycle's issue is rejected; the next cycle's issue gets id = old `head`, and `rob_full` re-asserts.
